// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, defaults and helpers for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic uart_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Two-flop synchronizer with async active-low reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8-bit UART receiver with optional even parity and
//               a single-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       parity_en,
    input  logic       rx_uart,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int                 c_HALF     = CLKS_PER_BIT / 2;
    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic w_rx_s;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx_uart),
        .sync_o  (w_rx_s)
    );

    uart_rx_state_t     state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;
    logic [1:0]         sync_fill_q, sync_fill_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               w_free;

    assign w_free = !valid_q || rx_data_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            sync_fill_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            sync_fill_q <= sync_fill_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        sync_fill_d = {sync_fill_q[0], 1'b1};
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = 1'b0;

        if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            // The synchronizer's reset value is not line data, so the idle
            // check waits until both flops have been refilled from rx_uart.
            WAIT_IDLE: begin
                if (sync_fill_q[1] && w_rx_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!w_rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == c_HALF_END) begin
                    cnt_d = '0;
                    if (!w_rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        par_en_d  = parity_en;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == c_BIT_END) begin
                    cnt_d   = '0;
                    shreg_d = {w_rx_s, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            PARITY: begin
                if (cnt_q == c_BIT_END) begin
                    cnt_d     = '0;
                    par_bit_d = w_rx_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == c_BIT_END) begin
                    cnt_d   = '0;
                    state_d = w_rx_s ? IDLE : WAIT_IDLE;
                    if (w_free) begin
                        data_d  = shreg_q;
                        perr_d  = par_en_q && (par_bit_q != uart_parity(shreg_q));
                        ferr_d  = ~w_rx_s;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign parity_err    = perr_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       parity_en;
    logic       rx_uart;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .parity_en     (parity_en),
        .rx_uart       (rx_uart),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge numbers are relative to the first posedge that samples the start bit.
    int t0 = 0;
    int valid_rises = 0, rise_edge = -1, valid_hi = 0;
    int busy_rise = -1, busy_fall = -1;
    int ovr_cnt = 0, ovr_edge = -1;
    logic valid_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_data_valid && !valid_prev) begin
            valid_rises++;
            rise_edge = cyc - t0 - 1;
        end
        if (rx_data_valid) valid_hi++;
        if (busy && !busy_prev) busy_rise = cyc - t0 - 1;
        if (!busy && busy_prev) busy_fall = cyc - t0 - 1;
        if (overrun_err) begin
            ovr_cnt++;
            ovr_edge = cyc - t0 - 1;
        end
        valid_prev = rx_data_valid;
        busy_prev  = busy;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        @(negedge clk);
        t0      = cyc;
        rx_uart = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_uart = d[i];
            repeat (C) @(negedge clk);
        end
        if (with_par) begin
            rx_uart = par_bit;
            repeat (C) @(negedge clk);
        end
        rx_uart = stop_bit;
        repeat (C) @(negedge clk);
    endtask

    int n0, h0, o0;

    initial begin
        reset         = 1'b0;
        rx_uart       = 1'b1;
        parity_en     = 1'b0;
        rx_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(rx_data_valid), 0);
        check_eq("rst_data",  32'(rx_data), 0);
        check_eq("rst_perr",  32'(parity_err), 0);
        check_eq("rst_ferr",  32'(frame_err), 0);
        check_eq("rst_ovr",   32'(overrun_err), 0);
        check_eq("rst_busy",  32'(busy), 1);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);

        // 0xA5, no parity, consumer always ready
        n0 = valid_rises; h0 = valid_hi;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("a5_data",  32'(rx_data), 32'hA5);
        check_eq("a5_rises", valid_rises - n0, 1);
        check_eq("a5_edge",  rise_edge, 154);
        check_eq("a5_hi",    valid_hi - h0, 1);
        check_eq("a5_perr",  32'(parity_err), 0);
        check_eq("a5_ferr",  32'(frame_err), 0);
        check_eq("a5_brise", busy_rise, 2);
        check_eq("a5_bfall", busy_fall, 154);

        // 0x3C with even parity, correct then wrong parity bit
        parity_en = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("p0_data", 32'(rx_data), 32'h3C);
        check_eq("p0_perr", 32'(parity_err), 0);
        check_eq("p0_edge", rise_edge, 170);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("p1_data", 32'(rx_data), 32'h3C);
        check_eq("p1_perr", 32'(parity_err), 1);
        check_eq("p1_edge", rise_edge, 170);
        parity_en = 1'b0;

        // Start-bit glitch of 4 clocks
        n0 = valid_rises;
        @(negedge clk);
        t0 = cyc; rx_uart = 1'b0;
        repeat (4) @(negedge clk);
        rx_uart = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("gl_rises", valid_rises - n0, 0);
        check_eq("gl_bfall", busy_fall, 10);
        check_eq("gl_busy",  32'(busy), 0);

        // Stop bit 0 followed by a long break
        n0 = valid_rises;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check_eq("br_data",  32'(rx_data), 32'h81);
        check_eq("br_ferr",  32'(frame_err), 1);
        check_eq("br_rises", valid_rises - n0, 1);
        check_eq("br_busy",  32'(busy), 1);
        rx_uart = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("br_rearm", 32'(busy), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("55_data", 32'(rx_data), 32'h55);
        check_eq("55_ferr", 32'(frame_err), 0);
        check_eq("55_edge", rise_edge, 154);

        // Overrun with consumer stalled
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("ov_valid1", 32'(rx_data_valid), 1);
        o0 = ovr_cnt;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("ov_count", ovr_cnt - o0, 1);
        check_eq("ov_edge",  ovr_edge, 154);
        check_eq("ov_data",  32'(rx_data), 32'h11);
        check_eq("ov_valid", 32'(rx_data_valid), 1);
        rx_data_ready = 1'b1;
        @(negedge clk);
        check_eq("acc_valid", 32'(rx_data_valid), 0);
        check_eq("acc_data",  32'(rx_data), 32'h11);

        // Reset during data bit 3, released while the line is low
        @(negedge clk);
        t0 = cyc; rx_uart = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_uart = ~rx_uart;
            repeat (C) @(negedge clk);
        end
        rx_uart = 1'b1;
        repeat (C / 2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_uart = ~rx_uart;
            @(negedge clk);
        end
        check_eq("mr_data", 32'(rx_data), 0);
        rx_uart = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n0 = valid_rises;
        repeat (40) @(negedge clk);
        check_eq("mr_rises", valid_rises - n0, 0);
        check_eq("mr_busy",  32'(busy), 1);
        rx_uart = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("mr_rearm", 32'(busy), 0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("f0_data", 32'(rx_data), 32'hF0);
        check_eq("f0_edge", rise_edge, 154);
        check_eq("f0_ferr", 32'(frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's existing UART transmit path.
- Oversamples the rx line at CLKS_PER_BIT clocks per bit. Frame format: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
- Delivers bytes through a single-entry valid/ready output register with parity, framing and overrun status.

Parameters:
- CLKS_PER_BIT, 16: clocks per bit period; must be even and ≥ 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- parity_en  in  1  1 = expect parity bit; latched at start-bit confirmation.
- rx_uart  in  1  serial line, asynchronous, idle high.
- rx_data  out  8  received byte.
- rx_data_valid  out  1  rx_data/status held valid until accepted.
- rx_data_ready  in  1  consumer accepts when valid && ready.
- parity_err  out  1  parity mismatch for the held byte.
- frame_err  out  1  stop bit sampled 0 for the held byte.
- overrun_err  out  1  one-cycle pulse: completed byte dropped because the output register was full.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (reset=0, async): state=WAIT_IDLE; counters = 0. Outputs: rx_data=0, rx_data_valid=0, parity_err=0, frame_err=0, overrun_err=0. Synchronizer flops reset to 1.
- Synchronizer: rx_uart passes through a 2-flop synchronizer; rx_s is the second flop output. All decisions use rx_s only.
- Counters: HALF = CLKS_PER_BIT/2. cnt counts 0..CLKS_PER_BIT-1. bit_idx is 3 bits.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This blocks a false start after reset or after a break.
- IDLE: on rx_s==0, go to START with cnt=0.
- START: at cnt==HALF-1:
  - if rx_s==0, the start bit is confirmed. Go to DATA, set cnt=0, bit_idx=0, latch parity_en.
  - otherwise it is a glitch; return to IDLE.
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg MSB-side (right shift) and set cnt=0. After bit_idx==7, go to PARITY if the latched parity_en is set, else STOP.
- PARITY: at cnt==CLKS_PER_BIT-1, capture par_bit and go to STOP. Even parity: error when par_bit != ^shreg.
- STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit and attempt delivery.
  - Next state is IDLE if rx_s==1.
  - Next state is WAIT_IDLE if rx_s==0 (framing error / break).
- Delivery at the stop-sample edge:
  - If the output register is free (!rx_data_valid, or rx_data_ready high that cycle): load rx_data=shreg, parity_err, frame_err=~rx_s; set rx_data_valid=1.
  - Otherwise: drop the byte, pulse overrun_err for one cycle, and leave the held byte and flags unchanged.
- Accept without a new byte: when valid && ready, clear rx_data_valid the next cycle. rx_data and flags hold their last values.
- Simultaneous accept + new byte: the new byte loads and valid stays 1. No overrun.
- Latency (CLKS_PER_BIT=16), taking edge 0 as the first clk edge that samples rx_uart=0:
  - START entered at edge 2; DATA at edge 10.
  - bit k sampled at edge 26+16k.
  - stop sampled, and rx_data_valid set, at edge 154 (170 with parity).
- parity_en changes mid-frame have no effect on the current frame.
- Async reset mid-frame: the partial byte is discarded and the receiver re-arms via WAIT_IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - DEFAULT_CLKS_PER_BIT=16;
  - uart_parity() function returning ^data (even parity).
- Sub-module uart_sync: 2-flop synchronizer with async active-low reset to a parameterised value (1 here).

Test Plan:
- Byte 0xA5, parity_en=0, ready=1 → rx_data=0xA5, valid pulses one cycle at edge 154, parity_err=0, frame_err=0, busy high edges 2..154.
- Byte 0x3C with parity bit 0, parity_en=1 → 0x3C, parity_err=0 at edge 170. Repeat with parity bit 1 → parity_err=1.
- Glitch: rx_uart low 4 clocks then high → back to IDLE by edge 10, no valid, busy drops.
- Stop bit 0 then line held low 100 clocks → byte delivered with frame_err=1; no new start detected until line high; next byte 0x55 received cleanly.
- ready=0, send 0x11 then 0x22 → 0x11 held, overrun_err pulses once at the 0x22 stop edge. Assert ready → valid drops, rx_data stays 0x11.
- Assert reset during DATA bit 3 with line toggling, release while line low → no valid until line high; next frame 0xF0 received correctly.
